// File: rtl/i2s_pkg.sv
// Constants and slot helpers shared by the I2S transmitter and receiver.
// Slot numbering is the BCLK slot count within a 64-slot frame.
package i2s_pkg;

  localparam int SLOTS_PER_FRAME      = 64;
  localparam int SLOT_W               = 6;
  localparam int DEFAULT_SAMPLE_WIDTH = 16;

  localparam int LEFT_MSB_SLOT  = 1;
  localparam int RIGHT_MSB_SLOT = 33;
  localparam int LR_RISE_SLOT   = 31;
  localparam int LR_FALL_SLOT   = 63;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    SEG_IDLE,
    SEG_LEFT,
    SEG_RIGHT
  } seg_e;

  // Which word, if any, owns the data line during a slot.
  function automatic seg_e slot_segment(input logic [SLOT_W-1:0] slot, input int width);
    int si;
    si = int'(slot);
    if (si >= LEFT_MSB_SLOT && si < LEFT_MSB_SLOT + width) return SEG_LEFT;
    if (si >= RIGHT_MSB_SLOT && si < RIGHT_MSB_SLOT + width) return SEG_RIGHT;
    return SEG_IDLE;
  endfunction

  function automatic logic slot_lrclk(input logic [SLOT_W-1:0] slot);
    int si;
    si = int'(slot);
    return (si >= LR_RISE_SLOT && si < LR_FALL_SLOT);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles the bit clock every CLK_DIV input cycles and flags
// the cycle on which each falling or rising transition is registered.
module i2s_bclk_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic bclk,
  output logic fall_evt,
  output logic rise_evt
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
    $error("i2s_bclk_gen: CLK_DIV must be even and at least 2");
  end

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             bclk_reg;
  logic             bclk_next;
  logic             wrap;

  assign wrap     = (cnt_reg == CNT_MAX);
  assign fall_evt = wrap & bclk_reg;
  assign rise_evt = wrap & ~bclk_reg;
  assign bclk     = bclk_reg;

  always_comb begin
    cnt_next  = wrap ? '0 : cnt_reg + 1'b1;
    bclk_next = wrap ? ~bclk_reg : bclk_reg;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_reg  <= '0;
      bclk_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      bclk_reg <= bclk_next;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-pair holding buffer feeding left/right shift registers,
// serialised MSB first into 64-slot frames timed by i2s_bclk_gen.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV      = 16,
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_left_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_right_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic                    bclk_out,
  output logic                    lrclk_out,
  output logic                    sdata_out,
  output logic                    underrun_out
);

  if (SAMPLE_WIDTH < 1 || SAMPLE_WIDTH > 31) begin : g_bad_width
    $error("i2s_tx: SAMPLE_WIDTH must be in 1..31");
  end

  logic fall_evt;
  logic unused_rise_evt;

  // The rise strobe is for receivers; the transmitter only acts on falls.
  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .bclk     (bclk_out),
    .fall_evt (fall_evt),
    .rise_evt (unused_rise_evt)
  );

  logic [SLOT_W-1:0]       slot_reg,    slot_next;
  logic [SAMPLE_WIDTH-1:0] hold_l_reg,  hold_l_next;
  logic [SAMPLE_WIDTH-1:0] hold_r_reg,  hold_r_next;
  logic                    full_reg,    full_next;
  logic                    ready_reg,   ready_next;
  logic [SAMPLE_WIDTH-1:0] shift_l_reg, shift_l_next;
  logic [SAMPLE_WIDTH-1:0] shift_r_reg, shift_r_next;
  logic                    lrclk_reg,   lrclk_next;
  logic                    sdata_reg,   sdata_next;
  logic                    underrun_reg, underrun_next;

  logic accept;
  logic frame_load;

  assign accept     = sample_valid_in & ready_reg;
  assign frame_load = fall_evt & (slot_reg == LAST_SLOT);

  always_comb begin
    slot_next     = slot_reg;
    hold_l_next   = hold_l_reg;
    hold_r_next   = hold_r_reg;
    full_next     = full_reg;
    shift_l_next  = shift_l_reg;
    shift_r_next  = shift_r_reg;
    lrclk_next    = lrclk_reg;
    sdata_next    = sdata_reg;
    underrun_next = 1'b0;

    if (fall_evt) begin
      slot_next = slot_reg + 1'b1;

      if (frame_load) begin
        if (full_reg) begin
          shift_l_next = hold_l_reg;
          shift_r_next = hold_r_reg;
          full_next    = 1'b0;
        end else begin
          shift_l_next  = '0;
          shift_r_next  = '0;
          underrun_next = 1'b1;
        end
      end

      lrclk_next = slot_lrclk(slot_next);

      case (slot_segment(slot_next, SAMPLE_WIDTH))
        SEG_LEFT: begin
          sdata_next   = shift_l_next[SAMPLE_WIDTH-1];
          shift_l_next = shift_l_next << 1;
        end
        SEG_RIGHT: begin
          sdata_next   = shift_r_next[SAMPLE_WIDTH-1];
          shift_r_next = shift_r_next << 1;
        end
        default: sdata_next = 1'b0;
      endcase
    end

    // Accept is only possible while empty, so it never collides with a
    // clearing load; an accept alongside an empty load simply waits a frame.
    if (accept) begin
      hold_l_next = sample_left_in;
      hold_r_next = sample_right_in;
      full_next   = 1'b1;
    end

    ready_next = ~full_next;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      slot_reg     <= LAST_SLOT;
      hold_l_reg   <= '0;
      hold_r_reg   <= '0;
      full_reg     <= 1'b0;
      ready_reg    <= 1'b0;
      shift_l_reg  <= '0;
      shift_r_reg  <= '0;
      lrclk_reg    <= 1'b0;
      sdata_reg    <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      slot_reg     <= slot_next;
      hold_l_reg   <= hold_l_next;
      hold_r_reg   <= hold_r_next;
      full_reg     <= full_next;
      ready_reg    <= ready_next;
      shift_l_reg  <= shift_l_next;
      shift_r_reg  <= shift_r_next;
      lrclk_reg    <= lrclk_next;
      sdata_reg    <= sdata_next;
      underrun_reg <= underrun_next;
    end
  end

  assign sample_ready_out = ready_reg;
  assign lrclk_out        = lrclk_reg;
  assign sdata_out        = sdata_reg;
  assign underrun_out     = underrun_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a cycle-arithmetic frame model checked every cycle, a BCLK
// receiver decoding words, and directed scenarios at CLK_DIV 16 and 4.
module tb_i2s_tx;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done [2];

  task automatic chk(input int div, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL div=%0d %s: got %h, expected %h at %0t", div, name, act, exp, $time);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam int C     = (gi == 0) ? 16 : 4;
      localparam int FRAME = 128 * C;

      logic         rst = 1'b0;
      logic         vld = 1'b0;
      logic [W-1:0] sl  = '0;
      logic [W-1:0] sr  = '0;
      logic         ready, bclk, lr, sd, under;

      i2s_tx #(
        .CLK_DIV      (C),
        .SAMPLE_WIDTH (W)
      ) u_dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .sample_left_in   (sl),
        .sample_right_in  (sr),
        .sample_valid_in  (vld),
        .sample_ready_out (ready),
        .bclk_out         (bclk),
        .lrclk_out        (lr),
        .sdata_out        (sd),
        .underrun_out     (under)
      );

      // Model: t = clock edges since reset release; every output follows
      // from t, the frame's loaded pair, and the handshake history.
      int           t = 0;
      bit           started = 1'b0;
      bit           full_m = 1'b0;
      logic [W-1:0] hold_l = '0, hold_r = '0, cur_l = '0, cur_r = '0;
      logic         e_bclk, e_lr, e_sd, e_under, e_ready;
      int           f_m, s_m;
      bit           acc_m, load_m;

      initial forever begin
        @(posedge clk);
        started = 1'b1;
        if (!rst) begin
          t = 0; full_m = 1'b0; cur_l = '0; cur_r = '0;
          e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0; e_under = 1'b0; e_ready = 1'b0;
        end else begin
          acc_m = vld && e_ready;
          t++;
          e_under = 1'b0;
          load_m = (t % (2 * C) == 0) && (((t / (2 * C)) - 1) % 64 == 0);
          if (load_m) begin
            if (full_m) begin
              cur_l = hold_l; cur_r = hold_r; full_m = 1'b0;
            end else begin
              cur_l = '0; cur_r = '0; e_under = 1'b1;
            end
          end
          if (acc_m) begin
            hold_l = sl; hold_r = sr; full_m = 1'b1;
          end
          e_ready = !full_m;
          e_bclk  = ((t / C) % 2) == 1;
          f_m     = t / (2 * C);
          s_m     = (f_m == 0) ? 63 : (f_m - 1) % 64;
          e_lr    = (s_m >= 31 && s_m <= 62);
          if (s_m >= 1 && s_m <= W)             e_sd = cur_l[W - s_m];
          else if (s_m >= 33 && s_m <= 32 + W)  e_sd = cur_r[W - (s_m - 32)];
          else                                  e_sd = 1'b0;
        end
      end

      // Compare process plus BCLK-rise receiver and timing monitor.
      int           under_cnt, first_under, b_rise, b_per, lr_rise, lr_per, pos;
      logic         last_lr, prev_b;
      logic [W-1:0] word, dec_l;
      logic [31:0]  dec_q [$];

      initial forever begin
        @(negedge clk);
        if (started) begin
          chk(C, "bclk",     32'(bclk),  32'(e_bclk));
          chk(C, "lrclk",    32'(lr),    32'(e_lr));
          chk(C, "sdata",    32'(sd),    32'(e_sd));
          chk(C, "underrun", 32'(under), 32'(e_under));
          chk(C, "ready",    32'(ready), 32'(e_ready));
        end
        if (t == 0) begin
          under_cnt = 0; first_under = -1; b_rise = -1; b_per = 0;
          lr_rise = -1; lr_per = 0; pos = -1; last_lr = 1'b0; prev_b = 1'b0;
          word = '0; dec_l = '0; dec_q.delete();
        end else begin
          if (under) begin
            under_cnt++;
            if (first_under < 0) first_under = t;
          end
          if (bclk && !prev_b) begin
            if (b_rise >= 0) b_per = t - b_rise;
            b_rise = t;
            if (lr && !last_lr) begin
              if (lr_rise >= 0) lr_per = t - lr_rise;
              lr_rise = t;
            end
            if (lr != last_lr) pos = 0;
            else pos++;
            last_lr = lr;
            if (pos >= 2 && pos <= W + 1) begin
              word = {word[W-2:0], sd};
              if (pos == W + 1) begin
                if (lr) dec_q.push_back({dec_l, word});
                else dec_l = word;
              end
            end
          end
          prev_b = bclk;
        end
      end

      function automatic logic [31:0] q_at(input int i);
        if (i < dec_q.size()) return dec_q[i];
        return 32'hDEAD_DEAD;
      endfunction

      task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0; vld = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
      endtask

      task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        int n;
        n = 0;
        sl = l; sr = r; vld = 1'b1;
        while (ready !== 1'b1 && n < 4 * FRAME) begin
          @(negedge clk);
          n++;
        end
        chk(C, "send_handshake", 32'(ready), 32'd1);
        @(negedge clk);
        vld = 1'b0; sl = 16'hDEAD; sr = 16'hBEEF;
        $display("div=%0d sent L=%h R=%h at t=%0d", C, l, r, t);
      endtask

      task automatic wait_to(input int n);
        int g;
        g = 0;
        while (t < n && g < 200000) begin
          @(negedge clk);
          g++;
        end
        chk(C, "wait_to_reached", 32'(t >= n), 32'd1);
      endtask

      if (gi == 0) begin : g_stim_default
        int stale;
        initial begin
          // Idle: no source at all.
          reset_dut();
          wait_to(4200);
          chk(C, "idle_first_underrun", 32'(first_under), 32'd32);
          chk(C, "idle_underrun_count", 32'(under_cnt),   32'd3);
          chk(C, "idle_bclk_period",    32'(b_per),       32'd32);
          chk(C, "idle_lrclk_period",   32'(lr_per),      32'd2048);
          chk(C, "idle_word0",          q_at(0),          32'h0);
          $display("div=%0d idle frames done", C);

          // Pair offered before the first frame.
          reset_dut();
          send(16'hA5C3, 16'h8001);
          wait_to(2100);
          chk(C, "first_pair_word0",     q_at(0),          32'hA5C3_8001);
          chk(C, "first_pair_underrun",  32'(first_under), 32'd2080);
          chk(C, "first_pair_under_cnt", 32'(under_cnt),   32'd1);

          // Valid raised exactly in the first load cycle.
          reset_dut();
          repeat (31) @(negedge clk);
          sl = 16'h1234; sr = 16'hABCD; vld = 1'b1;
          @(negedge clk);
          vld = 1'b0; sl = 16'hDEAD; sr = 16'hBEEF;
          $display("div=%0d offered L=1234 R=ABCD in load cycle", C);
          wait_to(4200);
          chk(C, "coincide_first_underrun", 32'(first_under), 32'd32);
          chk(C, "coincide_word0",          q_at(0),          32'h0);
          chk(C, "coincide_word1",          q_at(1),          32'h1234_ABCD);
          chk(C, "coincide_under_cnt",      32'(under_cnt),   32'd2);

          // Reset in the middle of the right word with the buffer full.
          reset_dut();
          send(16'h1111, 16'h2222);
          wait_to(40);
          send(16'h3C3C, 16'hC3C3);
          wait_to(1317);
          chk(C, "pre_reset_ready", 32'(ready), 32'd0);
          chk(C, "pre_reset_lrclk", 32'(lr),    32'd1);
          rst = 1'b0;
          @(negedge clk);
          chk(C, "in_reset_sdata", 32'(sd),    32'd0);
          chk(C, "in_reset_lrclk", 32'(lr),    32'd0);
          chk(C, "in_reset_bclk",  32'(bclk),  32'd0);
          chk(C, "in_reset_ready", 32'(ready), 32'd0);
          chk(C, "in_reset_under", 32'(under), 32'd0);
          repeat (3) @(negedge clk);
          rst = 1'b1;
          wait_to(2100);
          stale = 0;
          foreach (dec_q[i]) if (dec_q[i] == 32'h3C3C_C3C3) stale++;
          chk(C, "post_reset_first_underrun", 32'(first_under), 32'd32);
          chk(C, "post_reset_word0",          q_at(0),          32'h0);
          chk(C, "post_reset_stale_pairs",    32'(stale),       32'd0);
          $display("div=%0d mid-frame reset done", C);
          done[0] = 1'b1;
        end
      end else begin : g_stim_div4
        int k, acc_cnt;
        bit pend;
        initial begin
          // Fast divider, extreme sample values.
          reset_dut();
          send(16'h7FFF, 16'hFFFF);
          wait_to(1100);
          chk(C, "div4_word0",          q_at(0),          32'h7FFF_FFFF);
          chk(C, "div4_bclk_period",    32'(b_per),       32'd8);
          chk(C, "div4_lrclk_period",   32'(lr_per),      32'd512);
          chk(C, "div4_first_underrun", 32'(first_under), 32'd520);

          // Continuous source: pair k carries L=k, R=k^5A5A.
          reset_dut();
          k = 0; acc_cnt = 0;
          sl = 16'(k); sr = 16'(k) ^ 16'h5A5A; vld = 1'b1;
          while (t < 51300) begin
            pend = (ready === 1'b1);
            @(negedge clk);
            if (pend) begin
              acc_cnt++;
              k++;
              sl = 16'(k); sr = 16'(k) ^ 16'h5A5A;
            end
          end
          vld = 1'b0;
          chk(C, "stream_underruns", 32'(under_cnt),    32'd0);
          chk(C, "stream_accepts",   32'(acc_cnt),      32'd102);
          chk(C, "stream_decoded",   32'(dec_q.size()), 32'd100);
          for (int i = 0; i < 100; i++) begin
            chk(C, $sformatf("stream_pair%0d", i), q_at(i),
                {16'(i), 16'(i) ^ 16'h5A5A});
          end
          $display("div=%0d streamed %0d pairs", C, acc_cnt);
          done[1] = 1'b1;
        end
      end
    end
  endgenerate

  initial begin
    wait (done[0] && done[1]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: scenarios unfinished, done=%0b%0b", done[1], done[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
